// File: rtl/signed_delta_integrator.sv
// Rebuilds two's complement samples from sign+magnitude input and integrates
// a fixed-length burst of them into a saturating signed sum.
module signed_delta_integrator #(
  parameter int unsigned MAG_W     = 8,
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned N_SAMPLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_neg,
  input  logic [MAG_W-1:0] in_mag,
  output logic             in_ready,
  output logic             conv_valid,
  output logic [MAG_W:0]   conv_val,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  output logic             sat,
  output logic             busy
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CONV_W = MAG_W + 1;
  localparam int unsigned EXT_W  = ACC_W + 1;
  localparam int unsigned PAD_W  = ACC_W - MAG_W;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
  localparam logic [ACC_W-1:0] SUM_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SUM_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CONV_W-1:0]   conv_val_q, conv_val_d;
  logic                conv_valid_q, conv_valid_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic                sat_q, sat_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                sum_valid_q, sum_valid_d;

  logic                hs_c;
  logic [CONV_W-1:0]   mag_ext_c;
  logic [EXT_W-1:0]    sum_ext_c, conv_ext_c, total_c;

  // Handshake and sign-extended operands for the saturating adder
  assign hs_c       = in_valid && (state_q == S_ACCUM);
  assign mag_ext_c  = {1'b0, in_mag};
  assign sum_ext_c  = {sum_q[ACC_W-1], sum_q};
  assign conv_ext_c = {{PAD_W{conv_val_q[CONV_W-1]}}, conv_val_q};
  assign total_c    = sum_ext_c + conv_ext_c;

  // Next-state: conversion stage, accumulate stage, burst FSM, output decode
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    conv_val_d   = conv_val_q;
    conv_valid_d = 1'b0;
    sum_d        = sum_q;
    sat_d        = sat_q;

    if (hs_c) begin
      conv_val_d   = in_neg ? (CONV_W'(0) - mag_ext_c) : mag_ext_c;
      conv_valid_d = 1'b1;
    end

    // Top two bits of the widened sum differ only on overflow of ACC_W
    if (conv_valid_q) begin
      if (total_c[EXT_W-1] != total_c[ACC_W-1]) begin
        sum_d = total_c[EXT_W-1] ? SUM_MIN : SUM_MAX;
        sat_d = 1'b1;
      end else begin
        sum_d = total_c[ACC_W-1:0];
      end
    end

    // Burst control; the IDLE clear has priority over accumulation
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sum_d   = '0;
          sat_d   = 1'b0;
          count_d = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (hs_c) begin
          count_d = CNT_W'(count_q + 1'b1);
          if (count_q == LAST_CNT) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they register in step with it
  always_comb begin
    in_ready_d  = (state_d == S_ACCUM);
    busy_d      = (state_d != S_IDLE);
    sum_valid_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      conv_val_q   <= '0;
      conv_valid_q <= 1'b0;
      sum_q        <= '0;
      sat_q        <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      sum_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      conv_val_q   <= conv_val_d;
      conv_valid_q <= conv_valid_d;
      sum_q        <= sum_d;
      sat_q        <= sat_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      sum_valid_q  <= sum_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign conv_valid = conv_valid_q;
  assign conv_val   = conv_val_q;
  assign sum        = sum_q;
  assign sum_valid  = sum_valid_q;
  assign sat        = sat_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_signed_delta_integrator.sv
// Directed and randomized bursts against a plain-integer model of the integrator.
module tb_signed_delta_integrator;

  localparam int unsigned MAG_W = 8;
  localparam int unsigned ACC_W = 12;
  localparam int          N     = 16;
  localparam int          SMAX  = 2047;
  localparam int          SMIN  = -2048;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             in_valid;
  logic             in_neg;
  logic [MAG_W-1:0] in_mag;
  logic             in_ready;
  logic             conv_valid;
  logic [MAG_W:0]   conv_val;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sat;
  logic             busy;

  int n_assert = 0;
  int n_fail   = 0;

  bit q_neg[$];
  int q_mag[$];

  signed_delta_integrator #(.MAG_W(MAG_W), .ACC_W(ACC_W), .N_SAMPLES(N)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_neg(in_neg), .in_mag(in_mag), .in_ready(in_ready),
    .conv_valid(conv_valid), .conv_val(conv_val), .sum(sum),
    .sum_valid(sum_valid), .sat(sat), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit neg, input int mag);
    q_neg.push_back(neg);
    q_mag.push_back(mag);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) push(1'($urandom_range(1)), int'($urandom_range(255)));
  endtask

  // One complete burst from IDLE using the queued samples; start_at >= 0 pulses
  // start while the sample with that index is being offered.
  task automatic burst(input string name, input int gap_pct, input int start_at);
    int  msum, v, idx, budget;
    bit  msat, acc;
    @(negedge clock);
    chk({name, ":ready_idle"}, 32'(in_ready), 32'd0);
    chk({name, ":busy_idle"}, 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({name, ":busy_start"}, 32'(busy), 32'd1);
    chk({name, ":sum_clear"}, 32'(sum), 32'd0);
    chk({name, ":sat_clear"}, 32'(sat), 32'd0);
    msum = 0; msat = 1'b0; idx = 0; budget = 0;
    while (idx < N && budget < 2000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_neg   = q_neg[idx];
      in_mag   = MAG_W'(q_mag[idx]);
      start    = (start_at >= 0 && idx == start_at);
      acc      = in_valid && in_ready;
      @(negedge clock);
      start = 1'b0;
      if (acc) begin
        v = q_neg[idx] ? -q_mag[idx] : q_mag[idx];
        chk({name, ":conv_valid"}, 32'(conv_valid), 32'd1);
        chk({name, ":conv_val"}, 32'(conv_val), 32'(v & 32'h1FF));
        msum = msum + v;
        if (msum > SMAX) begin msum = SMAX; msat = 1'b1; end
        if (msum < SMIN) begin msum = SMIN; msat = 1'b1; end
        idx++;
      end
      budget++;
    end
    in_valid = 1'b0;
    if (idx < N) chk({name, ":timeout_accepts"}, 32'(idx), 32'(N));
    chk({name, ":ready_drain"}, 32'(in_ready), 32'd0);
    chk({name, ":sv_drain"}, 32'(sum_valid), 32'd0);
    chk({name, ":busy_drain"}, 32'(busy), 32'd1);
    @(negedge clock);
    chk({name, ":sum_valid"}, 32'(sum_valid), 32'd1);
    chk({name, ":sum"}, 32'(sum), 32'(msum & 32'hFFF));
    chk({name, ":sat"}, 32'(sat), 32'(msat));
    @(negedge clock);
    chk({name, ":sv_pulse"}, 32'(sum_valid), 32'd0);
    chk({name, ":busy_end"}, 32'(busy), 32'd0);
    chk({name, ":sum_hold"}, 32'(sum), 32'(msum & 32'hFFF));
    q_neg.delete();
    q_mag.delete();
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_neg = 1'b0; in_mag = '0;
    repeat (3) @(negedge clock);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:ready", 32'(in_ready), 32'd0);
    chk("rst:sum", 32'(sum), 32'd0);
    chk("rst:sat", 32'(sat), 32'd0);
    chk("rst:conv_val", 32'(conv_val), 32'd0);
    chk("rst:conv_valid", 32'(conv_valid), 32'd0);
    chk("rst:sum_valid", 32'(sum_valid), 32'd0);
    reset = 1'b0;

    // Unit steps back-to-back
    for (int i = 0; i < N; i++) push(1'b0, 1);
    burst("t1", 0, -1);

    // Conversion corners followed by random fill
    push(1'b1, 11); push(1'b1, 255); push(1'b1, 0); push(1'b0, 255);
    push_random(N - 4);
    burst("t2", 0, -1);

    // Positive and negative clamps, then clamp followed by recovery
    for (int i = 0; i < N; i++) push(1'b0, 255);
    burst("t3a", 0, -1);
    for (int i = 0; i < N; i++) push(1'b1, 255);
    burst("t3b", 0, -1);
    for (int i = 0; i < 10; i++) push(1'b0, 255);
    for (int i = 0; i < 6; i++) push(1'b1, 255);
    burst("t3c", 10, -1);

    // Alternating +5/-3 with input gaps
    for (int i = 0; i < 8; i++) begin push(1'b0, 5); push(1'b1, 3); end
    burst("t4", 40, -1);

    // start pulsed mid-burst
    push_random(N);
    burst("t5", 20, 5);

    // Reset after five accepted samples
    for (int i = 0; i < N; i++) push(1'b0, 1 + int'($urandom_range(100)));
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_neg = q_neg[i];
      in_mag = MAG_W'(q_mag[i]);
      @(negedge clock);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t6:busy", 32'(busy), 32'd0);
    chk("t6:ready", 32'(in_ready), 32'd0);
    chk("t6:sum", 32'(sum), 32'd0);
    chk("t6:conv_val", 32'(conv_val), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      seen = seen | sum_valid;
    end
    chk("t6:no_sum_valid", 32'(seen), 32'd0);
    burst("t6b", 0, -1);

    // Random bursts with random gaps
    for (int b = 0; b < 3; b++) begin
      push_random(N);
      burst("t7", int'($urandom_range(50)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
